// File: rtl/pinaipple_array_pkg.sv
// Shared types and defaults for the memristor array sequencer slice.
package pinaipple_array_pkg;

    // Operation codes as driven on the chip instruction pins.
    typedef enum logic [1:0] {
        OP_INFER = 2'b00,
        OP_RDREG = 2'b01,
        OP_RDMEM = 2'b10,
        OP_PROG  = 2'b11
    } array_op_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SAMPLE,
        DONE
    } seq_state_e;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 5;
    localparam int unsigned NUM_ARRAYS_DEFAULT = 4;

    // Largest of the four timing parameters; sizes the shared down-counter.
    function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/array_bit_sync.sv
// Two-flop synchronizer for the chip data return lines.
module array_bit_sync #(
    parameter int unsigned Width = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/array_op_sequencer.sv
// Sequences one program / read / inference operation at a time onto the
// memristor array pins with programmable setup, pulse, hold and sample timing.
module array_op_sequencer
    import pinaipple_array_pkg::*;
#(
    parameter int unsigned AddrWidth = ADDR_WIDTH_DEFAULT,
    parameter int unsigned NumArrays = NUM_ARRAYS_DEFAULT,
    parameter int unsigned SetupCyc  = 2,
    parameter int unsigned PulseCyc  = 8,
    parameter int unsigned HoldCyc   = 2,
    parameter int unsigned SampleCyc = 4
) (
    input  logic                 clk_sys_in,
    input  logic                 rst_sys_in,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [AddrWidth-1:0] req_row_i,
    input  logic [AddrWidth-1:0] req_col_i,
    input  logic                 req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [NumArrays-1:0] rsp_data_o,
    output logic                 busy_o,
    output logic [1:0]           instructions_o,
    output logic [AddrWidth-1:0] addr_row_o,
    output logic [AddrWidth-1:0] addr_col_o,
    output logic                 cbl_o,
    output logic                 cblen_o,
    output logic                 csl_o,
    output logic                 cwl_o,
    input  logic [NumArrays-1:0] bit_out_i
);

    localparam int unsigned MaxCyc = max_cyc(SetupCyc, PulseCyc, HoldCyc, SampleCyc);
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    if (SetupCyc < 1 || PulseCyc < 1 || HoldCyc < 1 || SampleCyc < 2) begin : g_bad_params
        $error("array_op_sequencer: illegal timing parameters");
    end

    seq_state_e            r_state, w_state_n;
    logic [CntW-1:0]       r_cnt, w_cnt_n;
    array_op_e             r_op, w_op_n;
    logic [AddrWidth-1:0]  r_row, r_col, w_row_n, w_col_n;
    logic                  r_wdata, w_wdata_n;
    logic                  w_accept;
    logic                  r_cbl, r_cblen, r_csl, r_cwl;
    logic                  w_cbl_n, w_cblen_n, w_csl_n, w_cwl_n;
    logic                  r_rsp_valid, r_ready, r_busy;
    logic [NumArrays-1:0]  r_rsp_data;
    logic [NumArrays-1:0]  w_sync;

    array_bit_sync #(.Width(NumArrays)) u_sync (
        .i_clk (clk_sys_in),
        .i_rst (rst_sys_in),
        .i_d   (bit_out_i),
        .o_q   (w_sync)
    );

    // Next-state, counter reload and registered-output decode of the next state.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt - CntW'(1);
        w_accept  = 1'b0;
        w_cbl_n   = 1'b0;
        w_cblen_n = 1'b0;
        w_csl_n   = 1'b0;
        w_cwl_n   = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_n = r_cnt;
                if (req_valid_i && r_ready) begin
                    w_accept  = 1'b1;
                    w_state_n = SETUP;
                    w_cnt_n   = CntW'(SetupCyc);
                end
            end
            SETUP: begin
                if (r_cnt == CntW'(1)) begin
                    w_state_n = PULSE;
                    w_cnt_n   = CntW'(PulseCyc);
                end
            end
            PULSE: begin
                if (r_cnt == CntW'(1)) begin
                    w_state_n = HOLD;
                    w_cnt_n   = CntW'(HoldCyc);
                end
            end
            HOLD: begin
                if (r_cnt == CntW'(1)) begin
                    if (r_op == OP_PROG) begin
                        w_state_n = DONE;
                        w_cnt_n   = CntW'(1);
                    end else begin
                        w_state_n = SAMPLE;
                        w_cnt_n   = CntW'(SampleCyc);
                    end
                end
            end
            SAMPLE: begin
                if (r_cnt == CntW'(1)) begin
                    w_state_n = DONE;
                    w_cnt_n   = CntW'(1);
                end
            end
            DONE: begin
                w_state_n = IDLE;
                w_cnt_n   = r_cnt;
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase

        w_op_n    = w_accept ? array_op_e'(req_op_i) : r_op;
        w_row_n   = w_accept ? req_row_i   : r_row;
        w_col_n   = w_accept ? req_col_i   : r_col;
        w_wdata_n = w_accept ? req_wdata_i : r_wdata;

        // Strobes are decoded from the state being entered so that they come
        // straight out of flops and line up with the state they belong to.
        case (w_state_n)
            SETUP: w_cbl_n = (w_op_n == OP_PROG) && w_wdata_n;
            PULSE: begin
                case (w_op_n)
                    OP_PROG: begin
                        w_cwl_n   = 1'b1;
                        w_cblen_n = 1'b1;
                        w_cbl_n   = w_wdata_n;
                    end
                    OP_RDMEM: begin
                        w_csl_n   = 1'b1;
                        w_cblen_n = 1'b1;
                    end
                    OP_RDREG: w_csl_n = 1'b1;
                    default: begin
                        w_csl_n   = 1'b1;
                        w_cblen_n = 1'b1;
                    end
                endcase
            end
            SAMPLE: w_csl_n = 1'b1;
            default: ;
        endcase
    end

    // State, timing counter and latched request (which also drives the chip
    // instruction/address pins and holds them through IDLE).
    always_ff @(posedge clk_sys_in) begin
        if (rst_sys_in) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= OP_INFER;
            r_row   <= '0;
            r_col   <= '0;
            r_wdata <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_op    <= w_op_n;
            r_row   <= w_row_n;
            r_col   <= w_col_n;
            r_wdata <= w_wdata_n;
        end
    end

    // Registered strobes and handshake/status flags.
    always_ff @(posedge clk_sys_in) begin
        if (rst_sys_in) begin
            r_cbl       <= 1'b0;
            r_cblen     <= 1'b0;
            r_csl       <= 1'b0;
            r_cwl       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_cbl       <= w_cbl_n;
            r_cblen     <= w_cblen_n;
            r_csl       <= w_csl_n;
            r_cwl       <= w_cwl_n;
            r_rsp_valid <= (w_state_n == DONE);
            r_ready     <= (w_state_n == IDLE);
            r_busy      <= (w_state_n != IDLE);
        end
    end

    // Response data: cleared on accept, loaded on the edge entering the last
    // SAMPLE cycle so it is stable through that cycle and the DONE pulse.
    always_ff @(posedge clk_sys_in) begin
        if (rst_sys_in) begin
            r_rsp_data <= '0;
        end else if (w_accept) begin
            r_rsp_data <= '0;
        end else if (r_state == SAMPLE && r_cnt == CntW'(2)) begin
            r_rsp_data <= w_sync;
        end
    end

    assign req_ready_o    = r_ready;
    assign busy_o         = r_busy;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_data_o     = r_rsp_data;
    assign instructions_o = r_op;
    assign addr_row_o     = r_row;
    assign addr_col_o     = r_col;
    assign cbl_o          = r_cbl;
    assign cblen_o        = r_cblen;
    assign csl_o          = r_csl;
    assign cwl_o          = r_cwl;

endmodule

// File: tb/tb_array_op_sequencer.sv
// Directed bench for array_op_sequencer: default timing instance plus a
// minimum-timing instance, both sharing request and data-return inputs.
module tb_array_op_sequencer;

    localparam int unsigned AW = 5;
    localparam int unsigned NA = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          a_valid = 1'b0;
    logic          b_valid = 1'b0;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_row = '0;
    logic [AW-1:0] req_col = '0;
    logic          req_wdata = 1'b0;
    logic [NA-1:0] bit_out = '0;

    logic a_ready, a_rsp_valid, a_busy, a_cbl, a_cblen, a_csl, a_cwl;
    logic b_ready, b_rsp_valid, b_busy, b_cbl, b_cblen, b_csl, b_cwl;
    logic [NA-1:0] a_rsp_data, b_rsp_data;
    logic [1:0]    a_instr, b_instr;
    logic [AW-1:0] a_arow, a_acol, b_arow, b_acol;

    array_op_sequencer #(
        .AddrWidth(AW), .NumArrays(NA), .SetupCyc(2), .PulseCyc(8), .HoldCyc(2), .SampleCyc(4)
    ) u_dut_a (
        .clk_sys_in(clk), .rst_sys_in(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
        .req_op_i(req_op), .req_row_i(req_row), .req_col_i(req_col), .req_wdata_i(req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_data_o(a_rsp_data), .busy_o(a_busy),
        .instructions_o(a_instr), .addr_row_o(a_arow), .addr_col_o(a_acol),
        .cbl_o(a_cbl), .cblen_o(a_cblen), .csl_o(a_csl), .cwl_o(a_cwl), .bit_out_i(bit_out)
    );

    array_op_sequencer #(
        .AddrWidth(AW), .NumArrays(NA), .SetupCyc(1), .PulseCyc(1), .HoldCyc(1), .SampleCyc(2)
    ) u_dut_b (
        .clk_sys_in(clk), .rst_sys_in(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_op_i(req_op), .req_row_i(req_row), .req_col_i(req_col), .req_wdata_i(req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_data_o(b_rsp_data), .busy_o(b_busy),
        .instructions_o(b_instr), .addr_row_o(b_arow), .addr_col_o(b_acol),
        .cbl_o(b_cbl), .cblen_o(b_cblen), .csl_o(b_csl), .cwl_o(b_cwl), .bit_out_i(bit_out)
    );

    logic          sel_b = 1'b0;
    logic          m_ready, m_busy, m_rsp, m_cbl, m_cblen, m_csl, m_cwl;
    logic [NA-1:0] m_data;
    logic [1:0]    m_instr;
    logic [AW-1:0] m_row, m_col;
    assign m_ready = sel_b ? b_ready     : a_ready;
    assign m_busy  = sel_b ? b_busy      : a_busy;
    assign m_rsp   = sel_b ? b_rsp_valid : a_rsp_valid;
    assign m_cbl   = sel_b ? b_cbl       : a_cbl;
    assign m_cblen = sel_b ? b_cblen     : a_cblen;
    assign m_csl   = sel_b ? b_csl       : a_csl;
    assign m_cwl   = sel_b ? b_cwl       : a_cwl;
    assign m_data  = sel_b ? b_rsp_data  : a_rsp_data;
    assign m_instr = sel_b ? b_instr     : a_instr;
    assign m_row   = sel_b ? b_arow      : a_arow;
    assign m_col   = sel_b ? b_acol      : a_acol;

    int total = 0;
    int bad   = 0;

    // Per-cycle history; bit/index c is the c-th cycle after the accept edge.
    logic [63:0]   v_cwl, v_cblen, v_cbl, v_csl, v_rsp, v_ready, v_busy;
    logic [1:0]    h_instr [64];
    logic [AW-1:0] h_row [64];
    logic [AW-1:0] h_col [64];
    logic [NA-1:0] h_data [64];

    int            rst_cyc = 0, chg_cyc = 0, drop_cyc = 0, nx_cyc = 0;
    logic [NA-1:0] chg_val = '0;
    logic [1:0]    nx_op = 2'b00;
    logic [AW-1:0] nx_row = '0, nx_col = '0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_events();
        rst_cyc = 0; chg_cyc = 0; drop_cyc = 0; nx_cyc = 0;
    endtask

    task automatic launch(input logic sel, input logic [1:0] op, input logic [AW-1:0] row,
                          input logic [AW-1:0] col, input logic wd, input logic hold);
        sel_b = sel;
        req_op = op; req_row = row; req_col = col; req_wdata = wd;
        #1;
        for (int i = 0; i < 100 && m_ready !== 1'b1; i++) tick(1);
        total++;
        if (m_ready !== 1'b1) begin
            bad++;
            $display("FAIL launch_ready got=%b want=1", m_ready);
        end
        if (sel) b_valid = 1'b1; else a_valid = 1'b1;
        tick(1);
        if (!hold) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
    endtask

    task automatic record(input int ncyc);
        v_cwl = '0; v_cblen = '0; v_cbl = '0; v_csl = '0; v_rsp = '0; v_ready = '0; v_busy = '0;
        for (int c = 1; c <= ncyc; c++) begin
            v_cwl[c] = m_cwl; v_cblen[c] = m_cblen; v_cbl[c] = m_cbl; v_csl[c] = m_csl;
            v_rsp[c] = m_rsp; v_ready[c] = m_ready; v_busy[c] = m_busy;
            h_instr[c] = m_instr; h_row[c] = m_row; h_col[c] = m_col; h_data[c] = m_data;
            if (c == chg_cyc) bit_out = chg_val;
            if (c == rst_cyc) rst = 1'b1;
            if (rst_cyc != 0 && c == rst_cyc + 1) rst = 1'b0;
            if (c == drop_cyc) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            if (c == nx_cyc) begin
                req_op = nx_op; req_row = nx_row; req_col = nx_col;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        req_op = 2'b11; req_row = 5'd9; req_col = 5'd4; req_wdata = 1'b1;
        tick(3);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", a_busy); end
        total++; if ({a_cbl, a_cblen, a_csl, a_cwl} !== 4'b0000) begin bad++;
            $display("FAIL rst_strobes got=%b want=0000", {a_cbl, a_cblen, a_csl, a_cwl}); end
        total++; if (a_instr !== 2'b00) begin bad++; $display("FAIL rst_instr got=%b want=00", a_instr); end
        total++; if ({a_arow, a_acol} !== '0) begin bad++;
            $display("FAIL rst_addr got=%0d/%0d want=0/0", a_arow, a_acol); end
        total++; if (a_rsp_valid !== 1'b0 || a_rsp_data !== 4'b0000) begin bad++;
            $display("FAIL rst_rsp got=%b/%b want=0/0000", a_rsp_valid, a_rsp_data); end
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL rst_busy_b got=%b want=0", b_busy); end
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
        tick(1);
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++;
            $display("FAIL rst_ready got=%b%b want=11", a_ready, b_ready); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b want=0", a_busy); end
    endtask

    task automatic test_prog();
        int nbad;
        clear_events();
        launch(1'b0, 2'b11, 5'd3, 5'd17, 1'b1, 1'b0);
        record(20);
        total++; if (v_cwl !== 64'h7F8) begin bad++; $display("FAIL prog_cwl got=%h want=7f8", v_cwl); end
        total++; if (v_cblen !== 64'h7F8) begin bad++; $display("FAIL prog_cblen got=%h want=7f8", v_cblen); end
        total++; if (v_cbl !== 64'h7FE) begin bad++; $display("FAIL prog_cbl got=%h want=7fe", v_cbl); end
        total++; if (v_csl !== 64'h0) begin bad++; $display("FAIL prog_csl got=%h want=0", v_csl); end
        total++; if (v_rsp !== 64'h2000) begin bad++; $display("FAIL prog_rsp got=%h want=2000", v_rsp); end
        total++; if (v_busy !== 64'h3FFE) begin bad++; $display("FAIL prog_busy got=%h want=3ffe", v_busy); end
        total++; if (h_data[13] !== 4'b0000) begin bad++; $display("FAIL prog_data got=%b want=0000", h_data[13]); end
        nbad = 0;
        for (int c = 1; c <= 20; c++) if (h_instr[c] !== 2'b11 || h_row[c] !== 5'd3 || h_col[c] !== 5'd17) nbad++;
        total++; if (nbad !== 0) begin bad++; $display("FAIL prog_instr_addr bad_cycles got=%0d want=0", nbad); end
    endtask

    task automatic test_read_mem();
        clear_events();
        bit_out = 4'b1010;
        tick(3);
        launch(1'b0, 2'b10, 5'd31, 5'd0, 1'b0, 1'b0);
        record(20);
        total++; if (v_csl !== 64'h1E7F8) begin bad++; $display("FAIL rdmem_csl got=%h want=1e7f8", v_csl); end
        total++; if (v_cblen !== 64'h7F8) begin bad++; $display("FAIL rdmem_cblen got=%h want=7f8", v_cblen); end
        total++; if ((v_cwl | v_cbl) !== 64'h0) begin bad++; $display("FAIL rdmem_cwl_cbl got=%h want=0", v_cwl | v_cbl); end
        total++; if (v_rsp !== 64'h20000) begin bad++; $display("FAIL rdmem_rsp got=%h want=20000", v_rsp); end
        total++; if (h_data[17] !== 4'b1010) begin bad++; $display("FAIL rdmem_data got=%b want=1010", h_data[17]); end
        total++; if (h_instr[5] !== 2'b10 || h_row[5] !== 5'd31 || h_col[5] !== 5'd0) begin bad++;
            $display("FAIL rdmem_addr got=%b/%0d/%0d want=10/31/0", h_instr[5], h_row[5], h_col[5]); end
    endtask

    task automatic test_read_reg_sample();
        clear_events();
        bit_out = 4'b0000;
        tick(3);
        chg_cyc = 14; chg_val = 4'b1111;
        launch(1'b0, 2'b01, 5'd7, 5'd8, 1'b0, 1'b0);
        record(20);
        total++; if (v_csl !== 64'h1E7F8 || v_cblen !== 64'h0) begin bad++;
            $display("FAIL rdreg_strobes got=csl %h cblen %h want=1e7f8/0", v_csl, v_cblen); end
        total++; if (v_rsp !== 64'h20000) begin bad++; $display("FAIL rdreg_rsp got=%h want=20000", v_rsp); end
        total++; if (h_data[17] !== 4'b0000) begin bad++; $display("FAIL rdreg_late_change got=%b want=0000", h_data[17]); end
        clear_events();
        bit_out = 4'b0000;
        tick(3);
        chg_cyc = 1; chg_val = 4'b1111;
        launch(1'b0, 2'b01, 5'd7, 5'd8, 1'b0, 1'b0);
        record(20);
        total++; if (h_data[17] !== 4'b1111) begin bad++; $display("FAIL rdreg_setup_change got=%b want=1111", h_data[17]); end
        total++; if (v_rsp !== 64'h20000) begin bad++; $display("FAIL rdreg_rsp2 got=%h want=20000", v_rsp); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_ready;
        int nbad;
        clear_events();
        bit_out = 4'b0011;
        tick(3);
        nx_cyc = 1; nx_op = 2'b01; nx_row = 5'd12; nx_col = 5'd20;
        drop_cyc = 19;
        launch(1'b0, 2'b10, 5'd5, 5'd9, 1'b0, 1'b1);
        record(40);
        exp_ready = (64'h1 << 18) | (64'h1F << 36);
        total++; if (v_ready !== exp_ready) begin bad++; $display("FAIL b2b_ready got=%h want=%h", v_ready, exp_ready); end
        total++; if (v_busy !== (64'h1FFFFFFFFFE & ~exp_ready)) begin bad++;
            $display("FAIL b2b_busy got=%h want=%h", v_busy, 64'h1FFFFFFFFFE & ~exp_ready); end
        total++; if (v_rsp !== ((64'h1 << 17) | (64'h1 << 35))) begin bad++;
            $display("FAIL b2b_rsp got=%h want=%h", v_rsp, (64'h1 << 17) | (64'h1 << 35)); end
        nbad = 0;
        for (int c = 3; c <= 10; c++) if (h_instr[c] !== 2'b10 || h_row[c] !== 5'd5 || h_col[c] !== 5'd9) nbad++;
        for (int c = 21; c <= 28; c++) if (h_instr[c] !== 2'b01 || h_row[c] !== 5'd12 || h_col[c] !== 5'd20) nbad++;
        total++; if (nbad !== 0) begin bad++; $display("FAIL b2b_pulse_addr bad_cycles got=%0d want=0", nbad); end
        total++; if (h_data[35] !== 4'b0011) begin bad++; $display("FAIL b2b_data got=%b want=0011", h_data[35]); end
    endtask

    task automatic test_reset_mid_op();
        clear_events();
        rst_cyc = 6;
        launch(1'b0, 2'b11, 5'd2, 5'd2, 1'b1, 1'b0);
        record(20);
        total++; if (v_cwl[6] !== 1'b1) begin bad++; $display("FAIL midrst_pre_cwl got=%b want=1", v_cwl[6]); end
        total++; if ({v_cbl[7], v_cblen[7], v_csl[7], v_cwl[7]} !== 4'b0000) begin bad++;
            $display("FAIL midrst_strobes got=%b want=0000", {v_cbl[7], v_cblen[7], v_csl[7], v_cwl[7]}); end
        total++; if (v_rsp !== 64'h0) begin bad++; $display("FAIL midrst_rsp got=%h want=0", v_rsp); end
        total++; if (v_busy !== 64'h7E) begin bad++; $display("FAIL midrst_busy got=%h want=7e", v_busy); end
        total++; if (v_ready[8] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", v_ready[8]); end
        total++; if (h_instr[7] !== 2'b00) begin bad++; $display("FAIL midrst_instr got=%b want=00", h_instr[7]); end
    endtask

    task automatic test_param_sweep();
        clear_events();
        bit_out = 4'b0110;
        tick(3);
        launch(1'b1, 2'b11, 5'd7, 5'd7, 1'b1, 1'b0);
        record(10);
        total++; if (v_rsp !== 64'h10) begin bad++; $display("FAIL min_prog_rsp got=%h want=10", v_rsp); end
        total++; if (v_cwl !== 64'h4 || v_cblen !== 64'h4) begin bad++;
            $display("FAIL min_prog_pulse got=cwl %h cblen %h want=4/4", v_cwl, v_cblen); end
        total++; if (v_cbl !== 64'h6) begin bad++; $display("FAIL min_prog_cbl got=%h want=6", v_cbl); end
        total++; if (v_busy !== 64'h1E) begin bad++; $display("FAIL min_prog_busy got=%h want=1e", v_busy); end
        launch(1'b1, 2'b10, 5'd1, 5'd30, 1'b0, 1'b0);
        record(10);
        total++; if (v_rsp !== 64'h40) begin bad++; $display("FAIL min_read_rsp got=%h want=40", v_rsp); end
        total++; if (v_csl !== 64'h34 || v_cblen !== 64'h4) begin bad++;
            $display("FAIL min_read_strobes got=csl %h cblen %h want=34/4", v_csl, v_cblen); end
        total++; if (h_data[6] !== 4'b0110) begin bad++; $display("FAIL min_read_data got=%b want=0110", h_data[6]); end
        total++; if (v_busy !== 64'h7E) begin bad++; $display("FAIL min_read_busy got=%h want=7e", v_busy); end
        sel_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prog();
        test_read_mem();
        test_read_reg_sample();
        test_back_to_back();
        test_reset_mid_op();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/array_op_sequencer.md
Name: array_op_sequencer

Overview:
- Sequences single operations on the off-chip memristor array: program, read_mem, read_reg and inference.
- Takes one request at a time from the system bus-side register block via a valid/ready handshake.
- Drives instruction code, row/col address and the CBL/CBLEN/CSL/CWL strobes with programmable setup/pulse/hold timing.
- For reads, samples the 4-bit DATA_out return and reports it with a one-cycle response pulse. Sits inside pinaipple_system between the CPU-side registers and the chip pins.

Parameters:
- AddrWidth, 5, width of row and col address.
- NumArrays, 4, number of bit_out lines (one per sub-array).
- SetupCyc, 2, cycles address/instruction are stable before the strobe (must be >=1).
- PulseCyc, 8, strobe active cycles (must be >=1).
- HoldCyc, 2, cycles address held after the strobe drops (must be >=1).
- SampleCyc, 4, read settle window; sampling occurs on its last cycle (must be >=2).

Ports:
- clk_sys_in  in  1  system clock
- rst_sys_in  in  1  reset; synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_op_i  in  2  11 prog, 10 read_mem, 01 read_reg, 00 inference
- req_row_i  in  AddrWidth  row address
- req_col_i  in  AddrWidth  col address
- req_wdata_i  in  1  programmed bit value, driven on CBL for prog
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  NumArrays  sampled bits; 0 for prog
- busy_o  out  1  high whenever the state is not IDLE
- instructions_o  out  2  to chip
- addr_row_o  out  AddrWidth  to chip
- addr_col_o  out  AddrWidth  to chip
- cbl_o, cblen_o, csl_o, cwl_o  out  1 each  chip strobes
- bit_out_i  in  NumArrays  chip data return; asynchronous to clk_sys_in

Behaviour:
- Reset values:
  - state IDLE.
  - All strobes 0, instructions_o 00, addresses 0.
  - rsp_valid_o 0, rsp_data_o 0, busy_o 0.
  - req_ready_o is 1 in the first cycle after reset deasserts.
- Requests presented while reset is high are ignored.
- All chip-facing outputs are registered; they change only on clock edges and never glitch.
- Accept: on an edge where req_valid_i && req_ready_o, latch op/row/col/wdata and enter SETUP. Call this edge E0.
- SETUP (SetupCyc cycles):
  - instructions_o and addresses are driven from the latched request.
  - All strobes are 0.
  - cbl_o = wdata for prog, 0 otherwise.
- PULSE (PulseCyc cycles), strobe pattern by op:
  - prog: cwl=1, cblen=1.
  - read_mem: csl=1, cblen=1.
  - read_reg: csl=1.
  - inference: csl=1, cblen=1.
- HOLD (HoldCyc cycles): all strobes 0, instruction/address unchanged.
  - Prog goes to DONE.
  - All other ops go to SAMPLE.
- SAMPLE (SampleCyc cycles):
  - csl stays 1 for reads; the other strobes stay 0.
  - On the last cycle, capture the synchronized bit_out into rsp_data_o.
  - Then go to DONE with csl=0.
- DONE (1 cycle): rsp_valid_o=1, then IDLE. There is no response backpressure.
- Address/instruction stay driven in IDLE (last values); strobes are 0 in IDLE.
- Latency from E0 to the rsp_valid_o cycle:
  - prog: Setup+Pulse+Hold+1 = 13 cycles at defaults.
  - reads/inference: Setup+Pulse+Hold+Sample+1 = 17 cycles at defaults.
- Throughput: the next accept is at the earliest in the IDLE cycle after DONE. Min spacing between accepts is latency+1.
- bit_out_i passes through a 2-flop synchronizer. SampleCyc>=2 guarantees the sampled value reflects the input as it was before SAMPLE started.
- Reset mid-operation: on the next edge all strobes go to 0, state goes to IDLE, and no rsp_valid_o is issued for the aborted op.
- req_valid_i while busy: ignored (ready=0). The requester holds the request.
- Timing counter: a single down-counter, width $clog2(max cycle param + 1), reloaded on each state entry. States with a count of 1 last exactly one cycle.
- Illegal parameter values trip elaboration assertions.

Decomposition:
- Package pinaipple_array_pkg holds:
  - array_op_e enum (OP_INFER=00, OP_RDREG=01, OP_RDMEM=10, OP_PROG=11).
  - seq_state_e enum (IDLE, SETUP, PULSE, HOLD, SAMPLE, DONE).
  - localparam defaults for AddrWidth and NumArrays.
- One sub-module, array_bit_sync: parameterized-width 2-flop synchronizer for bit_out_i, with reset clearing both stages to 0.

Test Plan:
- Prog at row 3, col 17, wdata=1 after reset:
  - cwl=cblen=cbl=1 for exactly 8 cycles starting 3 cycles after E0.
  - rsp_valid_o at E0+13 with rsp_data_o=0.
  - instructions_o=11 throughout.
- read_mem at row 31, col 0 with bit_out_i=1010 held:
  - csl/cblen pulse is 8 cycles.
  - rsp_valid_o at E0+17 with rsp_data_o=1010.
  - Exactly one rsp pulse.
- Back-to-back: req_valid_i held high with two reads:
  - Second accept occurs one cycle after the first DONE.
  - req_ready_o=0 for all intermediate cycles.
  - Address/instruction never change during PULSE.
- Reset asserted at the 4th PULSE cycle of a prog:
  - All strobes are 0 on the next edge.
  - No rsp_valid_o.
  - req_ready_o=1 one cycle after reset drops.
- read_reg with bit_out_i changing 0000 to 1111 at the 2nd SAMPLE cycle: rsp_data_o=0000 (value before change captured per sync latency). Repeat with the change at SETUP: result 1111.
- Parameter sweep Setup=1, Pulse=1, Hold=1, Sample=2: prog latency 4, read latency 6, 1-cycle strobe, all states visited.
